// File: rtl/chip8_alu_sequencer.sv
// ============================================================================
// chip8_alu_sequencer : sequences one CHIP-8 8XYN instruction through the
//                       register file and an external ALU.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package chip8_alu_pkg;
    typedef enum logic [3:0] {
        ALU_f_NOP    = 4'd0,
        ALU_f_OR     = 4'd1,
        ALU_f_AND    = 4'd2,
        ALU_f_XOR    = 4'd3,
        ALU_f_ADD    = 4'd4,
        ALU_f_MINUS  = 4'd5,
        ALU_f_RSHIFT = 4'd6,
        ALU_f_LSHIFT = 4'd7
    } ALU_f;
endpackage

module chip8_alu_sequencer
    import chip8_alu_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op_n,
    input  logic [3:0]  op_x,
    input  logic [3:0]  op_y,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  reg_raddr,
    input  logic [7:0]  reg_rdata,
    output logic        reg_we,
    output logic [3:0]  reg_waddr,
    output logic [7:0]  reg_wdata,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output ALU_f        alu_sel,
    input  logic [15:0] alu_out,
    input  logic [15:0] alu_carry
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ_X = 3'd1,
        S_READ_Y = 3'd2,
        S_EXEC   = 3'd3,
        S_WB_X   = 3'd4,
        S_WB_F   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  n_q, n_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  y_q, y_d;
    logic [7:0]  vx_q, vx_d;
    logic [7:0]  result_q, result_d;
    logic        flag_q, flag_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic [3:0]  reg_raddr_q, reg_raddr_d;
    logic        reg_we_q, reg_we_d;
    logic [3:0]  reg_waddr_q, reg_waddr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;

    logic        w_legal;
    logic        w_flag_op;
    logic        w_flag;
    logic        unused_bits;

    // The ALU carry port and the middle result bits carry no information here.
    assign unused_bits = ^{alu_carry, alu_out[14:9]};

    always_comb begin
        w_legal   = 1'b0;
        w_flag_op = 1'b0;
        case (n_q)
            4'h0, 4'h1, 4'h2, 4'h3: w_legal = 1'b1;
            4'h4, 4'h5, 4'h6, 4'h7, 4'hE: begin
                w_legal   = 1'b1;
                w_flag_op = 1'b1;
            end
            default: begin
                w_legal   = 1'b0;
                w_flag_op = 1'b0;
            end
        endcase
    end

    // vy is not registered: the read issued in READ_Y returns during EXEC.
    always_comb begin
        alu_sel = ALU_f_NOP;
        alu_in1 = 16'h0000;
        alu_in2 = 16'h0000;
        if (state_q == S_EXEC) begin
            case (n_q)
                4'h0: begin alu_sel = ALU_f_OR;     alu_in1 = {8'h00, reg_rdata}; end
                4'h1: begin alu_sel = ALU_f_OR;     alu_in1 = {8'h00, vx_q}; alu_in2 = {8'h00, reg_rdata}; end
                4'h2: begin alu_sel = ALU_f_AND;    alu_in1 = {8'h00, vx_q}; alu_in2 = {8'h00, reg_rdata}; end
                4'h3: begin alu_sel = ALU_f_XOR;    alu_in1 = {8'h00, vx_q}; alu_in2 = {8'h00, reg_rdata}; end
                4'h4: begin alu_sel = ALU_f_ADD;    alu_in1 = {8'h00, vx_q}; alu_in2 = {8'h00, reg_rdata}; end
                4'h5: begin alu_sel = ALU_f_MINUS;  alu_in1 = {8'h00, vx_q}; alu_in2 = {8'h00, reg_rdata}; end
                4'h7: begin alu_sel = ALU_f_MINUS;  alu_in1 = {8'h00, reg_rdata}; alu_in2 = {8'h00, vx_q}; end
                4'h6: begin alu_sel = ALU_f_RSHIFT; alu_in1 = {8'h00, vx_q}; alu_in2 = 16'h0001; end
                4'hE: begin alu_sel = ALU_f_LSHIFT; alu_in1 = {8'h00, vx_q}; alu_in2 = 16'h0001; end
                default: begin
                    alu_sel = ALU_f_NOP;
                    alu_in1 = 16'h0000;
                    alu_in2 = 16'h0000;
                end
            endcase
        end
    end

    always_comb begin
        w_flag = 1'b0;
        case (n_q)
            4'h4:       w_flag = alu_out[8];
            4'h5, 4'h7: w_flag = ~alu_out[15];
            4'h6:       w_flag = vx_q[0];
            4'hE:       w_flag = vx_q[7];
            default:    w_flag = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        x_d      = x_q;
        y_d      = y_q;
        vx_d     = vx_q;
        result_d = result_q;
        flag_d   = flag_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ_X;
                    n_d     = op_n;
                    x_d     = op_x;
                    y_d     = op_y;
                end
            end
            S_READ_X: state_d = S_READ_Y;
            S_READ_Y: begin
                state_d = S_EXEC;
                vx_d    = reg_rdata;
            end
            S_EXEC: begin
                state_d  = S_WB_X;
                result_d = alu_out[7:0];
                flag_d   = w_flag;
            end
            S_WB_X:  state_d = S_WB_F;
            S_WB_F:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed for the state being entered so they register cleanly.
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        illegal_d   = (state_d == S_DONE) && !w_legal;

        reg_raddr_d = 4'h0;
        if (state_d == S_READ_X) begin
            reg_raddr_d = x_d;
        end else if (state_d == S_READ_Y) begin
            reg_raddr_d = y_q;
        end

        reg_we_d    = 1'b0;
        reg_waddr_d = 4'h0;
        reg_wdata_d = 8'h00;
        if (state_d == S_WB_X && w_legal) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = x_q;
            reg_wdata_d = result_d;
        end else if (state_d == S_WB_F && w_flag_op) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = 4'hF;
            reg_wdata_d = {7'b0000000, flag_q};
        end
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= 4'h0;
            x_q         <= 4'h0;
            y_q         <= 4'h0;
            vx_q        <= 8'h00;
            result_q    <= 8'h00;
            flag_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            reg_raddr_q <= 4'h0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= 4'h0;
            reg_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vx_q        <= vx_d;
            result_q    <= result_d;
            flag_q      <= flag_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            reg_raddr_q <= reg_raddr_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign illegal   = illegal_q;
    assign reg_raddr = reg_raddr_q;
    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;

endmodule

`default_nettype wire

// File: doc/chip8_alu_sequencer.md
CHIP8_ALU_SEQUENCER -- requirements
Module: chip8_alu_sequencer

Interface
REQ-001 SHALL have these ports:
- cpu_clk, input, 1: the single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
REQ-002 SHALL have these command ports:
- start, input, 1: request to execute one 8XYN instruction.
- op_n, input, 4: N nibble.
- op_x, input, 4: X index.
- op_y, input, 4: Y index.
REQ-003 SHALL have these status outputs:
- busy, output, 1: high from acceptance until done.
- done, output, 1: one-cycle completion pulse.
- illegal, output, 1: one-cycle pulse coincident with done for an unsupported N.
REQ-004 SHALL have these register-file ports:
- reg_raddr, output, 4: read address; synchronous read, data valid one cycle later.
- reg_rdata, input, 8: read data.
- reg_we, output, 1: write enable.
- reg_waddr, output, 4: write address.
- reg_wdata, output, 8: write data.
REQ-005 SHALL have these ALU ports:
- alu_in1, output, 16.
- alu_in2, output, 16.
- alu_sel, output, ALU_f: operation select.
- alu_out, input, 16: ALU result.
- alu_carry, input, 16: ALU carry; unused.

Function
REQ-006 SHALL implement FSM IDLE→READ_X→READ_Y→EXEC→WB_X→WB_F→DONE→IDLE, one cycle per state outside IDLE.
REQ-007 SHALL accept start only in IDLE, latching op_n/op_x/op_y; start outside IDLE SHALL be ignored.
REQ-008 SHALL assert done, for one cycle in DONE, exactly 6 cycles after the accepting edge, for every N.
REQ-009 SHALL assert busy in every state except IDLE.
REQ-010 SHALL drive reg_raddr=X in READ_X and reg_raddr=Y in READ_Y; vx captured at the end of READ_Y, vy at the end of EXEC's entry edge.
REQ-011 SHALL, in EXEC, drive ALU operands zero-extended to 16 bits:
- N=0 (LD): OR, vy, 0.
- N=1: OR, vx, vy.
- N=2: AND, vx, vy.
- N=3: XOR, vx, vy.
- N=4: ADD, vx, vy.
- N=5: MINUS, vx, vy.
- N=7: MINUS, vy, vx.
- N=6: RSHIFT, vx, 1.
- N=E: LSHIFT, vx, 1.
REQ-012 SHALL register result=alu_out[7:0] at the end of EXEC.
REQ-013 SHALL compute and register the flag at the end of EXEC (alu_carry unused):
- ADD: alu_out[8].
- SUB/SUBN: ~alu_out[15] (1 when minuend ≥ subtrahend).
- SHR: vx[0].
- SHL: vx[7].
REQ-014 SHALL, in WB_X for a legal N, drive reg_we=1, reg_waddr=X, reg_wdata=result.
REQ-015 SHALL, in WB_F for N∈{4,5,6,7,E}, drive reg_we=1, reg_waddr=4'hF, reg_wdata={7'b0,flag}; for other N, reg_we=0.
REQ-016 SHALL write the flag after the result, so for X=F the final VF is the flag.
REQ-017 SHALL, for N∈{8..D,F}, perform no register writes, and pulse illegal with done in DONE.
REQ-018 SHALL keep reg_we=0 in all states except WB_X/WB_F as specified.
REQ-019 SHALL drive alu_sel=ALU_f_NOP and ALU operands to 0 outside EXEC.
REQ-020 SHALL produce results with 8-bit wrap-around (ADD 0xFF+0x01 → 0x00, flag 1).

Reset
REQ-021 SHALL, while reset is high, force the FSM to IDLE and drive these values asynchronously: busy=0, done=0, illegal=0, reg_we=0, reg_raddr=0, reg_waddr=0, reg_wdata=0, alu_sel=ALU_f_NOP.
REQ-022 SHALL clear all latched operands, result and flag to 0 on reset.
REQ-023 SHALL abort an in-flight operation on reset with no further writes, and accept a new start on the first edge after reset deasserts.

Verification
REQ-024 ADD: V1=0xF0, V2=0x20, start N=4, X=1, Y=2 -> V1=0x10, VF=0x01; done exactly 6 cycles after acceptance; busy high for cycles 1-6.
REQ-025 SUB/SUBN:
- V1=0x10, V2=0x20, N=5 -> V1=0xF0, VF=0.
- V1=V2=0x33, N=5 -> V1=0x00, VF=1.
- V1=0x10, V2=0x20, N=7 -> V1=0x10, VF=1.
REQ-026 Shifts:
- V1=0x81, N=E -> V1=0x02, VF=1.
- V1=0x03, N=6 -> V1=0x01, VF=1.
- V1=0x02, N=6 -> V1=0x01, VF=0.
REQ-027 Flag/result collision: VF=0xFF, V1=0x01, N=4, X=F, Y=1 -> WB_X writes VF=0x00, WB_F writes VF=0x01; final VF=0x01.
REQ-028 Illegal N and busy-start:
- N=8 -> no reg_we for the whole operation; illegal and done pulse together.
- start asserted during busy -> ignored; exactly one done.
REQ-029 Reset mid-operation: reset asserted during EXEC -> reg_we, busy and done go low immediately with no writes; a new N=1 op afterwards completes correctly (V1=0x0F|0xF0=0xFF).
